uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 166 ++++++++++++++++
 tb/tb_uart_tx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter draining an upstream FIFO: 8N1 frames, LSB first, back-to-back when data waits.
// Optional even-parity bit between data and stop when macro UART_TX_PARITY_EN is defined.
module uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] fifo_dout,
  input  logic       fifo_empty,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_t;
`endif

  state_t        state, next_state;
  logic [CW-1:0] cnt, next_cnt;
  logic [2:0]    idx, next_idx;
  logic [7:0]    shreg, next_shreg;
  logic          next_tx, next_busy, next_rd_en;
  logic          bit_end;

  assign bit_end = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= 3'd0;
      shreg      <= 8'h00;
      tx         <= 1'b1;
      busy       <= 1'b0;
      fifo_rd_en <= 1'b0;
    end else begin
      state      <= next_state;
      cnt        <= next_cnt;
      idx        <= next_idx;
      shreg      <= next_shreg;
      tx         <= next_tx;
      busy       <= next_busy;
      fifo_rd_en <= next_rd_en;
    end
  end

  // Outputs are computed one edge early so tx/busy/fifo_rd_en come straight from flops.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    next_idx   = idx;
    next_shreg = shreg;
    next_tx    = tx;
    next_busy  = busy;
    next_rd_en = 1'b0;

    case (state)
      IDLE: begin
        next_tx   = 1'b1;
        next_busy = 1'b0;
        next_cnt  = '0;
        next_idx  = 3'd0;
        if (!fifo_empty) begin
          next_shreg = fifo_dout;
          next_tx    = 1'b0;
          next_busy  = 1'b1;
          next_rd_en = 1'b1;
          next_cnt   = RELOAD;
          next_state = START;
        end
      end

      START: begin
        if (bit_end) begin
          next_cnt   = RELOAD;
          next_idx   = 3'd0;
          next_tx    = shreg[0];
          next_state = DATA;
        end else begin
          next_cnt = cnt - 1'b1;
        end
      end

      DATA: begin
        if (bit_end) begin
          next_cnt = RELOAD;
          if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            next_tx    = ^shreg;
            next_state = PARITY;
`else
            next_tx    = 1'b1;
            next_state = STOP;
`endif
          end else begin
            next_idx = idx + 3'd1;
            next_tx  = shreg[next_idx];
          end
        end else begin
          next_cnt = cnt - 1'b1;
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          next_cnt   = RELOAD;
          next_tx    = 1'b1;
          next_state = STOP;
        end else begin
          next_cnt = cnt - 1'b1;
        end
      end
`endif

      STOP: begin
        if (bit_end) begin
          // Last stop cycle doubles as the capture point, so queued bytes leave no idle gap.
          if (!fifo_empty) begin
            next_shreg = fifo_dout;
            next_tx    = 1'b0;
            next_busy  = 1'b1;
            next_rd_en = 1'b1;
            next_cnt   = RELOAD;
            next_idx   = 3'd0;
            next_state = START;
          end else begin
            next_tx    = 1'b1;
            next_busy  = 1'b0;
            next_cnt   = '0;
            next_idx   = 3'd0;
            next_state = IDLE;
          end
        end else begin
          next_cnt = cnt - 1'b1;
        end
      end

      default: begin
        next_state = IDLE;
        next_cnt   = '0;
        next_idx   = 3'd0;
        next_tx    = 1'b1;
        next_busy  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx at CLKS_PER_BIT=4: a FIFO model feeds bytes, a monitor decodes frames.
module tb_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CYC = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] fifo_dout;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic       tx;
  logic       busy;

  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .tx         (tx),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // seq lists start, 8 data bits (LSB first) and stop in send order, left to right.
  typedef struct {
    logic [9:0] seq;
    logic       par;
  } exp_t;

  int         vectors = 0;
  int         miscompares = 0;
  int         cycle = 0;
  exp_t       sb_q[$];
  logic [7:0] fifo_q[$];
  int         rd_times[$];

  logic in_frame = 1'b0;
  logic just_ended = 1'b0;
  exp_t cur;
  int   sidx, tx_err, busy_err, rd_err, first_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void fifo_update();
    fifo_empty = (fifo_q.size() == 0);
    fifo_dout  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endfunction

  function automatic logic exp_bit(input exp_t e, input int s);
    int b;
    b = s / CPB;
    if (b <= 8) return e.seq[9 - b];
`ifdef UART_TX_PARITY_EN
    if (b == 9) return e.par;
`endif
    return e.seq[0];
  endfunction

  task automatic push_frame(input logic [7:0] d, input logic [9:0] seq, input logic par);
    exp_t e;
    #1;
    e.seq = seq;
    e.par = par;
    fifo_q.push_back(d);
    sb_q.push_back(e);
    fifo_update();
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || fifo_q.size() != 0 || in_frame || busy) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("drain within budget", n < 1000, 1);
  endtask

  always @(posedge clk) cycle <= cycle + 1;

  // Upstream FIFO model: one pop per cycle in which fifo_rd_en is high.
  always @(negedge clk) begin
    if (fifo_rd_en) begin
      rd_times.push_back(cycle);
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      fifo_update();
    end
  end

  // Monitor: a low tx outside a frame starts one; every cycle of the frame is compared.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame   = 1'b0;
      just_ended = 1'b0;
    end else begin
      if (!in_frame && tx === 1'b0) begin
        if (sb_q.size() == 0) begin
          check("unexpected frame", 1, 0);
          cur.seq = 10'h3FF;
          cur.par = 1'b1;
        end else begin
          cur = sb_q.pop_front();
        end
        in_frame   = 1'b1;
        just_ended = 1'b0;
        sidx       = 0;
        tx_err     = 0;
        busy_err   = 0;
        rd_err     = 0;
        first_bad  = -1;
      end else if (!in_frame && just_ended) begin
        check("idle tx after frame", tx, 1);
        check("idle busy after frame", busy, 0);
        just_ended = 1'b0;
      end
      if (in_frame) begin
        if (tx !== exp_bit(cur, sidx)) begin
          tx_err++;
          if (first_bad < 0) first_bad = sidx;
        end
        if (busy !== 1'b1) busy_err++;
        if (fifo_rd_en !== (sidx == 0)) rd_err++;
        sidx++;
        if (sidx == FRAME_CYC) begin
          if (tx_err != 0) $display("first bad tx sample %0d", first_bad);
          check("frame tx wrong samples", tx_err, 0);
          check("frame busy low samples", busy_err, 0);
          check("frame rd_en wrong samples", rd_err, 0);
          in_frame   = 1'b0;
          just_ended = 1'b1;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad_tx, bad_busy;
    fifo_update();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset tx", tx, 1);
    check("reset busy", busy, 0);
    check("reset rd_en", fifo_rd_en, 0);
    rst_n = 1'b1;

    // Empty FIFO after reset: line stays idle.
    rd_times.delete();
    bad_tx = 0;
    bad_busy = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1) bad_tx++;
      if (busy !== 1'b0) bad_busy++;
    end
    check("idle200 tx not high", bad_tx, 0);
    check("idle200 busy high", bad_busy, 0);
    check("idle200 rd_en pulses", rd_times.size(), 0);

    // Single byte 0xA5.
    rd_times.delete();
    push_frame(8'hA5, 10'b0101001011, 1'b0);
    wait_done();
    check("A5 rd_en pulses", rd_times.size(), 1);

    // 0x00 then 0xFF queued together: back-to-back frames.
    rd_times.delete();
    push_frame(8'h00, 10'b0000000001, 1'b0);
    push_frame(8'hFF, 10'b0111111111, 1'b0);
    wait_done();
    check("b2b rd_en pulses", rd_times.size(), 2);
    if (rd_times.size() == 2)
      check("b2b rd_en spacing", rd_times[1] - rd_times[0], FRAME_CYC);

    // Parity vectors: 0x07 has odd weight (parity 1), 0x03 even (parity 0).
    push_frame(8'h07, 10'b0111000001, 1'b1);
    wait_done();
    push_frame(8'h03, 10'b0110000001, 1'b0);
    wait_done();

    // Reset during data bit 3 of 0xF0 (bit 3 is 0, so tx is low when reset hits).
    push_frame(8'hF0, 10'b0000011111, 1'b0);
    begin
      int n;
      n = 0;
      while (!in_frame && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("F0 frame started", in_frame, 1);
    end
    repeat (17) @(negedge clk);
    check("F0 tx in data bit 3", tx, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset tx", tx, 1);
    check("async reset busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rd_times.delete();
    repeat (20) @(negedge clk);
    check("post-reset rd_en pulses", rd_times.size(), 0);
    check("post-reset tx", tx, 1);

    // Normal traffic resumes once data is offered.
    push_frame(8'h3C, 10'b0001111001, 1'b0);
    wait_done();
    check("3C rd_en pulses", rd_times.size(), 1);
    check("scoreboard empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
